// File: rtl/integrator_splitter_if.sv
// integrator_splitter_if: sum-in and element-out valid/ready streams of the splitter
interface integrator_splitter_if #(parameter int sW = 16, parameter int bW = 8);
  logic [sW-1:0] sum;
  logic sum_vld, sum_rdy;
  logic [bW-1:0] d;
  logic d_vld, d_rdy, d_last;
  modport master(output sum, sum_vld, d_rdy, input sum_rdy, d, d_vld, d_last);
  modport slave(input sum, sum_vld, d_rdy, output sum_rdy, d, d_vld, d_last);
endinterface

// File: rtl/integrator_splitter.sv
// integrator_splitter: splits one sum into eC saturating elements via a sequential restoring divider
module integrator_splitter #(
  parameter int bW = 8,
  parameter int sW = 16,
  parameter int eC = 8
) (
  input logic clk,
  input logic rst,
  integrator_splitter_if.slave io
);
  localparam int aW = $clog2(eC + 1);
  localparam int cW = $clog2(sW) + 1;
  localparam logic [aW:0] ec = (aW + 1)'(eC);
  localparam logic [sW:0] max_d = (sW + 1)'(2 ** bW - 1);
  typedef enum logic [1:0] {IDLE, DIV, EMIT} state_t;
  state_t state, nxt;
  logic [sW-1:0] q;
  logic [aW-1:0] r, idx;
  logic [cW-1:0] cnt;
  logic [aW:0] sh;
  logic ge, last;
  logic [sW:0] e;
  // q doubles as the dividend shift register; quotient bits enter at the LSB
  always_comb begin
    sh = {r, q[sW-1]};
    ge = sh >= ec;
    last = idx == aW'(eC - 1);
    e = {1'b0, q} + (sW + 1)'(idx < r);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    nxt = state == IDLE ? (io.sum_vld ? DIV : IDLE)
        : state == DIV ? (cnt == cW'(sW - 1) ? EMIT : DIV)
        : (io.d_rdy && last ? IDLE : EMIT);
  end
  always_comb begin
    io.sum_rdy = state == IDLE && !rst;
    io.d_vld = state == EMIT;
    io.d_last = state == EMIT && last;
    io.d = state != EMIT ? '0 : e > max_d ? max_d[bW-1:0] : e[bW-1:0];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      q <= '0;
      r <= '0;
      idx <= '0;
      cnt <= '0;
    end else if (state == IDLE && io.sum_vld) begin
      q <= io.sum;
      r <= '0;
      cnt <= '0;
    end else if (state == DIV) begin
      q <= {q[sW-2:0], ge};
      r <= ge ? aW'(sh - ec) : sh[aW-1:0];
      cnt <= cnt + 1'b1;
      idx <= '0;
    end else if (state == EMIT && io.d_rdy) begin
      idx <= last ? '0 : idx + 1'b1;
    end
endmodule

// File: tb/tb_integrator_splitter.sv
// tb_integrator_splitter: directed vectors for the sum splitter with hand-computed element tables
module tb_integrator_splitter;
  logic clk = 0, rst;
  int n_checks = 0, n_errors = 0;
  int ev[8];
  logic [3:0] pat = 4'b1001;
  localparam int E19[8] = '{3, 3, 3, 2, 2, 2, 2, 2};
  localparam int E0[8] = '{0, 0, 0, 0, 0, 0, 0, 0};
  localparam int ESAT[8] = '{255, 255, 255, 255, 255, 255, 255, 255};
  localparam int E100[8] = '{13, 13, 13, 13, 12, 12, 12, 12};
  integrator_splitter_if #(.sW(16), .bW(8)) io();
  integrator_splitter #(.bW(8), .sW(16), .eC(8)) dut(.clk(clk), .rst(rst), .io(io.slave));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic start_group(input int s);
    int lat = 0;
    check("rdy_idle", io.sum_rdy, 1);
    io.sum = 16'(s);
    io.sum_vld = 1;
    @(posedge clk);
    #1 io.sum_vld = 0;
    io.sum = 16'hBEEF;
    for (lat = 0; lat < 100; ) begin
      @(negedge clk);
      if (lat == 0) check("rdy_div", io.sum_rdy, 0);
      if (io.d_vld) break;
      @(posedge clk);
      lat++;
    end
    check("latency", lat, 16);
  endtask
  task automatic drain(input int n, input bit bp);
    int i = 0, cyc = 0;
    logic [7:0] pd = 0;
    logic pl = 0;
    bit st = 0;
    while (i < n && cyc < 200) begin
      check("vld_hold", io.d_vld, 1);
      if (st) begin
        check("d_stable", io.d, pd);
        check("last_stable", io.d_last, pl);
      end
      io.d_rdy = bp ? pat[cyc % 4] : 1'b1;
      if (io.d_rdy) begin
        check("elem", io.d, ev[i]);
        check("last", io.d_last, i == 7);
        i++;
        st = 0;
      end else begin
        st = 1;
        pd = io.d;
        pl = io.d_last;
      end
      cyc++;
      @(negedge clk);
    end
    io.d_rdy = 1;
    if (i < n) check("drain_timeout", i, n);
  endtask
  task automatic run_group(input int s, input bit bp);
    start_group(s);
    drain(8, bp);
    check("rdy_after", io.sum_rdy, 1);
    check("vld_after", io.d_vld, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int acc, ones, last_hs, gap;
    bit prev_vld, drop;
    rst = 1;
    io.sum_vld = 0;
    io.sum = 0;
    io.d_rdy = 1;
    #1;
    check("rst_rdy", io.sum_rdy, 0);
    check("rst_vld", io.d_vld, 0);
    check("rst_d", io.d, 0);
    check("rst_last", io.d_last, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    check("rdy_release", io.sum_rdy, 1);
    ev = E19;
    run_group(19, 0);
    ev = E0;
    run_group(0, 0);
    ev = ESAT;
    run_group(65535, 0);
    ev = E100;
    run_group(100, 1);
    // sum_vld held high across two groups; it is dropped right after the second accept
    io.sum = 8;
    io.sum_vld = 1;
    acc = 0;
    ones = 0;
    last_hs = -1;
    gap = -1;
    prev_vld = 0;
    for (int n = 0; n < 120 && ones < 16; n++) begin
      drop = 0;
      if (io.sum_vld && io.sum_rdy) begin
        acc++;
        drop = acc == 2;
      end
      if (io.d_vld) begin
        check("busy_rdy", io.sum_rdy, 0);
        check("b2b_elem", io.d, 1);
        ones++;
        if (io.d_last) last_hs = n;
      end
      if (io.d_vld && !prev_vld && last_hs >= 0 && gap < 0) gap = n - 1 - last_hs;
      prev_vld = io.d_vld;
      @(posedge clk);
      #1 if (drop) io.sum_vld = 0;
      @(negedge clk);
    end
    check("accepts", acc, 2);
    check("b2b_count", ones, 16);
    check("b2b_gap", gap, 17);
    ev = E19;
    start_group(19);
    drain(3, 0);
    io.d_rdy = 0;
    #2 rst = 1;
    #1;
    check("arst_vld", io.d_vld, 0);
    check("arst_rdy", io.sum_rdy, 0);
    check("arst_last", io.d_last, 0);
    #1 rst = 0;
    @(negedge clk);
    check("arst_rdy_rel", io.sum_rdy, 1);
    check("arst_vld_rel", io.d_vld, 0);
    io.d_rdy = 1;
    run_group(19, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
